fc_layer_engine: RTL and testbench
==================================

# fc_layer_engine

Parametrised fully-connected layer engine for the inference datapath. It is an Avalon-MM master that streams packed signed weights and packed input activations from SDRAM. For each output node it accumulates the dot product over all inputs, applies optional ReLU and 16-bit saturation, and writes one result word per node. Base addresses are runtime inputs, so one instance serves every dense layer (784→200, 200→10, …) under control of the HPS `ready`/`done` handshake.

## Interface
Parameters:
- `N_IN`, default 784: inputs per node; must be a multiple of `LANES` (elaboration error otherwise).
- `N_OUT`, default 200: output nodes.
- `W_BITS`, default 4: field width of weights and activations; legal values 4, 8, 16.
- `LANES`, derived as 16/`W_BITS`: fields per 16-bit word, processed in parallel.
- `RELU`, default 0: when 1, negative accumulators are written as 0.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset.
- `ready`  in  1  start request; sampled only in IDLE.
- `act_mode`  in  1  0 = binary (bit 0 of each activation field gates its weight), 1 = signed multiply; sampled at start.
- `in_base`, `w_base`, `out_base`  in  32 each  byte base addresses; sampled at start.
- `waitrequest`  in  1  Avalon slave stall.
- `readdatavalid`  in  1  read data strobe.
- `readdata`  in  16  read data.
- `chipselect`  out  1  constant 1.
- `byteenable`  out  2  constant 2'b11.
- `read_n`, `write_n`  out  1 each  active-low strobes.
- `address`  out  32  byte address.
- `writedata`  out  16  result word.
- `done`  out  1  run complete.
- `status`  out  32  {node_cnt[15:0], word_cnt[11:0], state[3:0]} for hex display.

## Operation
- WPR = `N_IN`/`LANES` words per row. Weights are row-major: word k of node j is at `w_base` + 2·(j·WPR + k). Activation word k is at `in_base` + 2·k and is re-read for every node. Result j is written to `out_base` + 2·j.
- Field i of a word is bits [i·W_BITS +: W_BITS], signed two's complement.
- MAC adds Σ over lanes of (binary mode: act[0] ? w : 0; multiply mode: act·w) into a 32-bit signed accumulator. Operands are sign-extended before summing. No overflow is possible at the default sizes.
- Writeback: if `RELU` is set and acc < 0, the value becomes 0. The result is then saturated to [-32768, 32767].
- States:
  - IDLE: on `ready`, latch the bases and `act_mode`, clear the counters → RD_W.
  - RD_W: → WT_W when `waitrequest` is low.
  - WT_W: latch weight on `readdatavalid` → RD_X.
  - RD_X: → WT_X when `waitrequest` is low.
  - WT_X: latch activation on `readdatavalid` → MAC.
  - MAC: accumulate, word_cnt+1 → RD_W if word_cnt < WPR−1, else WR.
  - WR: → NEXT when `waitrequest` is low.
  - NEXT: clear acc and word_cnt, node_cnt+1 → RD_W if more nodes remain, else DONE.
  - DONE: → IDLE when `ready` is low.
- Only one bus transaction is outstanding at a time.
- `ready` falling mid-run is ignored; the run completes.

## Timing
- Reset values: `read_n`=1, `write_n`=1, `address`=0, `writedata`=0, `done`=0, all counters and acc 0, state IDLE.
- Reset mid-run aborts on the next edge; no further strobes are issued.
- `read_n` is low only in RD_W/RD_X, and `write_n` is low only in WR.
- `address` (and `writedata` in WR) are registered and held stable while `waitrequest` is high.
- `readdatavalid` is ignored outside WT_W/WT_X.
- With zero wait states and `readdatavalid` one cycle after accept, each word takes 5 cycles and each node takes 5·WPR+2 cycles. Total run = 1 + `N_OUT`·(5·WPR+2) cycles from the `ready` sample to entering DONE.
- `done` is high exactly while in DONE.
- `status` updates on the same edge as state changes.

## Test plan
- Binary, N_IN=8, N_OUT=2, W_BITS=4. Activations 0x1111, weights 0x1111 → writes 0x0008 to `out_base` and `out_base`+2; run length 25 cycles.
- Binary, RELU=0 then RELU=1. Activations 0x0101, weights 0xFFFF, N_IN=8 → writes 0xFFFC, then 0x0000.
- Multiply mode, W_BITS=8, N_IN=4. Activations and weights all 0x7F7F → acc 64516 saturates → writes 0x7FFF. With weights 0x8080 → writes 0x8000.
- `waitrequest` held 3 cycles on every read and write, `readdatavalid` delayed 2 cycles → same results as the zero-wait run; `address`, `read_n` and `write_n` are stable through each stall.
- `reset_n` low in MAC of node 1 → next cycle `read_n`=`write_n`=1, `done`=0, no write. A fresh `ready` restarts at node 0 with the correct results.
- `ready` held high after completion → stays in DONE, no new bus traffic. `ready` low → IDLE next cycle. `ready` re-asserted → an identical second run.

Source files
------------

// File: rtl/fc_layer_engine_if.sv
// Avalon-MM bus bundle between the fully-connected layer engine and SDRAM.
// The engine drives the master side; the memory responder uses the slave side.
interface fc_layer_engine_if;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [15:0] writedata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;

  modport master (
    output chipselect, byteenable, read_n, write_n, address, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  chipselect, byteenable, read_n, write_n, address, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/fc_layer_engine.sv
// Dense-layer engine: streams packed weights/activations over Avalon-MM, accumulates one
// dot product per output node, applies optional ReLU and 16-bit saturation, writes results.
module fc_layer_engine #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 200,
  parameter int W_BITS = 4,
  parameter int RELU   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ready,
  input  logic                act_mode,
  input  logic [31:0]         in_base,
  input  logic [31:0]         w_base,
  input  logic [31:0]         out_base,
  fc_layer_engine_if.master   bus,
  output logic                done,
  output logic [31:0]         status
);
  localparam int LANES = 16 / W_BITS;
  localparam int WPR   = N_IN / LANES;
  localparam logic [11:0] LAST_WORD = 12'(WPR - 1);
  localparam logic [15:0] LAST_NODE = 16'(N_OUT - 1);

  if (W_BITS != 4 && W_BITS != 8 && W_BITS != 16) begin : g_bad_w_bits
    $error("fc_layer_engine: W_BITS must be 4, 8 or 16");
  end
  if ((N_IN % LANES) != 0) begin : g_bad_n_in
    $error("fc_layer_engine: N_IN must be a multiple of LANES");
  end

  typedef enum logic [3:0] {
    IDLE = 4'd0, RD_W = 4'd1, WT_W = 4'd2, RD_X = 4'd3, WT_X = 4'd4,
    MAC  = 4'd5, WR   = 4'd6, NEXT = 4'd7, DONE = 4'd8
  } state_t;

  state_t             state;
  logic               read_n_r, write_n_r, done_r, mode_r;
  logic [31:0]        address_r, w_ptr, x_ptr, o_ptr, in_base_r;
  logic [15:0]        writedata_r, w_word, x_word, node_cnt;
  logic [11:0]        word_cnt;
  logic signed [31:0] acc, mac_sum;

  // Sum of all lanes of one word pair; binary mode lets activation bit 0 gate the weight.
  function automatic logic signed [31:0] lane_sum(input logic [15:0] w, input logic [15:0] x,
                                                  input logic mul);
    logic signed [31:0]       sum;
    logic signed [W_BITS-1:0] wf, xf;
    sum = 32'sd0;
    for (int i = 0; i < LANES; i++) begin
      wf = w[i*W_BITS +: W_BITS];
      xf = x[i*W_BITS +: W_BITS];
      if (mul) sum = sum + 32'(wf) * 32'(xf);
      else     sum = sum + (xf[0] ? 32'(wf) : 32'sd0);
    end
    return sum;
  endfunction

  function automatic logic [15:0] wb_value(input logic signed [31:0] a);
    logic signed [31:0] v;
    v = (RELU != 0 && a < 32'sd0) ? 32'sd0 : a;
    if (v > 32'sd32767)       return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  assign mac_sum        = acc + lane_sum(w_word, x_word, mode_r);
  assign bus.chipselect = 1'b1;
  assign bus.byteenable = 2'b11;
  assign bus.read_n     = read_n_r;
  assign bus.write_n    = write_n_r;
  assign bus.address    = address_r;
  assign bus.writedata  = writedata_r;
  assign done           = done_r;
  assign status         = {node_cnt, word_cnt, state};

  // Control FSM; every bus strobe and address is set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      read_n_r    <= 1'b1;
      write_n_r   <= 1'b1;
      done_r      <= 1'b0;
      mode_r      <= 1'b0;
      address_r   <= 32'd0;
      writedata_r <= 16'd0;
      w_ptr       <= 32'd0;
      x_ptr       <= 32'd0;
      o_ptr       <= 32'd0;
      in_base_r   <= 32'd0;
      w_word      <= 16'd0;
      x_word      <= 16'd0;
      node_cnt    <= 16'd0;
      word_cnt    <= 12'd0;
      acc         <= 32'sd0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          mode_r    <= act_mode;
          in_base_r <= in_base;
          x_ptr     <= in_base;
          o_ptr     <= out_base;
          address_r <= w_base;
          w_ptr     <= w_base + 32'd2;
          node_cnt  <= 16'd0;
          word_cnt  <= 12'd0;
          acc       <= 32'sd0;
          read_n_r  <= 1'b0;
          state     <= RD_W;
        end
        RD_W: if (!bus.waitrequest) begin
          read_n_r <= 1'b1;
          state    <= WT_W;
        end
        WT_W: if (bus.readdatavalid) begin
          w_word    <= bus.readdata;
          address_r <= x_ptr;
          x_ptr     <= x_ptr + 32'd2;
          read_n_r  <= 1'b0;
          state     <= RD_X;
        end
        RD_X: if (!bus.waitrequest) begin
          read_n_r <= 1'b1;
          state    <= WT_X;
        end
        WT_X: if (bus.readdatavalid) begin
          x_word <= bus.readdata;
          state  <= MAC;
        end
        MAC: begin
          acc      <= mac_sum;
          word_cnt <= word_cnt + 12'd1;
          if (word_cnt < LAST_WORD) begin
            address_r <= w_ptr;
            w_ptr     <= w_ptr + 32'd2;
            read_n_r  <= 1'b0;
            state     <= RD_W;
          end else begin
            writedata_r <= wb_value(mac_sum);
            address_r   <= o_ptr;
            o_ptr       <= o_ptr + 32'd2;
            write_n_r   <= 1'b0;
            state       <= WR;
          end
        end
        WR: if (!bus.waitrequest) begin
          write_n_r <= 1'b1;
          state     <= NEXT;
        end
        NEXT: begin
          acc      <= 32'sd0;
          word_cnt <= 12'd0;
          node_cnt <= node_cnt + 16'd1;
          x_ptr    <= in_base_r;
          if (node_cnt < LAST_NODE) begin
            address_r <= w_ptr;
            w_ptr     <= w_ptr + 32'd2;
            read_n_r  <= 1'b0;
            state     <= RD_W;
          end else begin
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: if (!ready) begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          read_n_r  <= 1'b1;
          write_n_r <= 1'b1;
          done_r    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench: three engine configurations, each with its own SDRAM responder, checked against
// directed expectations and a field-level reference model of the layer arithmetic.
module tb_fc_layer_engine;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ready    [3];
  logic        act_mode [3];
  logic [31:0] in_base  [3];
  logic [31:0] w_base   [3];
  logic [31:0] out_base [3];
  logic        done     [3];
  logic [31:0] status   [3];

  logic [15:0] mem [3][1024];
  int          stall_cfg [3];
  int          lat_cfg   [3];
  bit          junk_en   [3];
  int          wr_cnt    [3];
  int          req_cnt   [3];
  int          rd_cnt    [3];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          xf [8];
  int          wf [3][8];

  always #5 clk = ~clk;

  function automatic int nin(input int g);   return (g == 2) ? 4 : 8; endfunction
  function automatic int nout(input int g);  return (g == 2) ? 3 : 2; endfunction
  function automatic int wbits(input int g); return (g == 2) ? 8 : 4; endfunction

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fc_layer_engine_if bus ();

    fc_layer_engine #(
      .N_IN  ((g == 2) ? 4 : 8),
      .N_OUT ((g == 2) ? 3 : 2),
      .W_BITS((g == 2) ? 8 : 4),
      .RELU  ((g == 1) ? 1 : 0)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ready   (ready[g]),
      .act_mode(act_mode[g]),
      .in_base (in_base[g]),
      .w_base  (w_base[g]),
      .out_base(out_base[g]),
      .bus     (bus),
      .done    (done[g]),
      .status  (status[g])
    );

    int          pend = 0;
    int          left = 0;
    bit          busy = 1'b0;
    logic [31:0] raddr;
    logic [49:0] held;

    initial begin
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = 16'd0;
    end

    // SDRAM responder: configurable stall, read latency and stray readdatavalid pulses.
    always @(negedge clk) begin
      bus.readdatavalid = 1'b0;
      if (!reset_n) begin
        pend = 0;
        busy = 1'b0;
        bus.waitrequest = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = mem[g][raddr[10:1]];
          end
        end
        if (!bus.read_n || !bus.write_n) begin
          if (!busy) begin
            busy = 1'b1;
            left = stall_cfg[g];
            held = {bus.address, bus.writedata, bus.read_n, bus.write_n};
            req_cnt[g]++;
          end else begin
            check_value($sformatf("stall_hold%0d", g),
                        {14'd0, bus.address, bus.writedata, bus.read_n, bus.write_n},
                        {14'd0, held});
          end
          if (left > 0) begin
            bus.waitrequest = 1'b1;
            left--;
          end else begin
            bus.waitrequest = 1'b0;
            busy = 1'b0;
            if (!bus.read_n) begin
              raddr = bus.address;
              pend  = lat_cfg[g];
              rd_cnt[g]++;
            end else begin
              mem[g][bus.address[10:1]] = bus.writedata;
              wr_cnt[g]++;
            end
          end
        end else begin
          bus.waitrequest = 1'b0;
          if (pend == 0 && !bus.readdatavalid && junk_en[g] && $urandom_range(0, 1) == 1) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = 16'($urandom);
          end
        end
      end
    end
  end

  task automatic fill(input int g, input logic [15:0] xw, input logic [15:0] ww);
    for (int k = 0; k < 16; k++) mem[g][int'(in_base[g][10:1]) + k] = xw;
    for (int k = 0; k < 64; k++) mem[g][int'(w_base[g][10:1]) + k] = ww;
    for (int k = 0; k < 8; k++)  mem[g][int'(out_base[g][10:1]) + k] = 16'hDEAD;
  endtask

  task automatic check_all(input int g, input logic [15:0] val, input string tag);
    for (int j = 0; j < nout(g); j++)
      check_value($sformatf("%s_d%0d_n%0d", tag, g, j),
                  {48'd0, mem[g][int'(out_base[g][10:1]) + j]}, {48'd0, val});
  endtask

  // Start a run, wait for done, optionally keep ready high, then release it.
  task automatic run(input int g, input logic mode, input int hold, output int cycles);
    int r0;
    act_mode[g] = mode;
    ready[g]    = 1'b1;
    cycles      = 0;
    while (cycles < 4000 && !done[g]) begin
      @(posedge clk);
      cycles++;
      #1;
    end
    check_value($sformatf("run_done%0d", g), {63'd0, done[g]}, 64'd1);
    r0 = req_cnt[g];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_value("done_held", {63'd0, done[g]}, 64'd1);
    end
    if (hold > 0) check_value("no_traffic_in_done", 64'(req_cnt[g]), 64'(r0));
    ready[g] = 1'b0;
    @(posedge clk); #1;
    check_value($sformatf("done_drop%0d", g), {63'd0, done[g]}, 64'd0);
  endtask

  task automatic load_random(input int g);
    int wb, lanes, wpr;
    logic [15:0] word;
    wb    = wbits(g);
    lanes = 16 / wb;
    wpr   = nin(g) / lanes;
    for (int i = 0; i < nin(g); i++) begin
      xf[i] = int'($urandom_range(0, (1 << wb) - 1)) - (1 << (wb - 1));
      for (int j = 0; j < nout(g); j++)
        wf[j][i] = int'($urandom_range(0, (1 << wb) - 1)) - (1 << (wb - 1));
    end
    for (int k = 0; k < wpr; k++) begin
      word = 16'd0;
      for (int l = 0; l < lanes; l++) word |= 16'((xf[k*lanes+l] & ((1 << wb) - 1)) << (l*wb));
      mem[g][int'(in_base[g][10:1]) + k] = word;
      for (int j = 0; j < nout(g); j++) begin
        word = 16'd0;
        for (int l = 0; l < lanes; l++)
          word |= 16'((wf[j][k*lanes+l] & ((1 << wb) - 1)) << (l*wb));
        mem[g][int'(w_base[g][10:1]) + j*wpr + k] = word;
      end
    end
    for (int k = 0; k < 8; k++) mem[g][int'(out_base[g][10:1]) + k] = 16'hDEAD;
  endtask

  function automatic logic [15:0] model_node(input int g, input int j, input logic mode);
    longint acc;
    acc = 0;
    for (int i = 0; i < nin(g); i++)
      acc += mode ? longint'(xf[i] * wf[j][i]) : (((xf[i] & 1) != 0) ? longint'(wf[j][i]) : 0);
    if (g == 1 && acc < 0) acc = 0;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  initial begin
    int cyc, w0, r0;
    bit found;
    reset_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ready[g] = 1'b0; act_mode[g] = 1'b0;
      in_base[g] = 32'h100; w_base[g] = 32'h200; out_base[g] = 32'h600;
      stall_cfg[g] = 0; lat_cfg[g] = 1; junk_en[g] = 1'b0;
      wr_cnt[g] = 0; req_cnt[g] = 0; rd_cnt[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_read_n",    {63'd0, g_dut[0].bus.read_n},  64'd1);
    check_value("rst_write_n",   {63'd0, g_dut[0].bus.write_n}, 64'd1);
    check_value("rst_address",   {32'd0, g_dut[0].bus.address}, 64'd0);
    check_value("rst_writedata", {48'd0, g_dut[0].bus.writedata}, 64'd0);
    check_value("rst_done",      {63'd0, done[0]}, 64'd0);
    check_value("rst_status",    {32'd0, status[0]}, 64'd0);
    check_value("const_cs_be",   {61'd0, g_dut[0].bus.chipselect, g_dut[0].bus.byteenable}, 64'd7);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Binary all-ones fields: 8 per node.
    fill(0, 16'h1111, 16'h1111);
    run(0, 1'b0, 0, cyc);
    check_all(0, 16'h0008, "bin_ones");
    check_value("run_len", 64'(cyc), 64'd25);
    check_value("write_count", 64'(wr_cnt[0]), 64'd2);

    // Alternating gates with -1 weights, without and with ReLU.
    fill(0, 16'h0101, 16'hFFFF);
    run(0, 1'b0, 0, cyc);
    check_all(0, 16'hFFFC, "bin_neg");
    fill(1, 16'h0101, 16'hFFFF);
    run(1, 1'b0, 0, cyc);
    check_all(1, 16'h0000, "relu_neg");

    // 8-bit multiply mode saturating high and low.
    fill(2, 16'h7F7F, 16'h7F7F);
    run(2, 1'b1, 0, cyc);
    check_all(2, 16'h7FFF, "sat_hi");
    fill(2, 16'h7F7F, 16'h8080);
    run(2, 1'b1, 0, cyc);
    check_all(2, 16'h8000, "sat_lo");

    // Stalled bus must give the zero-wait results.
    stall_cfg[0] = 3; lat_cfg[0] = 2; junk_en[0] = 1'b1;
    fill(0, 16'h1111, 16'h1111);
    run(0, 1'b0, 0, cyc);
    check_all(0, 16'h0008, "stall");
    stall_cfg[0] = 0; lat_cfg[0] = 1; junk_en[0] = 1'b0;

    // Reset while in MAC of node 1: the sixth read is node 1's first activation.
    fill(0, 16'h1111, 16'h1111);
    w0 = wr_cnt[0]; r0 = rd_cnt[0]; found = 1'b0;
    act_mode[0] = 1'b0; ready[0] = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (rd_cnt[0] == r0 + 6 && g_dut[0].bus.readdatavalid) found = 1'b1;
    end
    check_value("reach_mac_node1", {63'd0, found}, 64'd1);
    @(posedge clk); #1;
    check_value("mac_node_cnt", {48'd0, status[0][31:16]}, 64'd1);
    reset_n = 1'b0; ready[0] = 1'b0;
    @(posedge clk); #1;
    check_value("abort_read_n",  {63'd0, g_dut[0].bus.read_n},  64'd1);
    check_value("abort_write_n", {63'd0, g_dut[0].bus.write_n}, 64'd1);
    check_value("abort_done",    {63'd0, done[0]}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_value("abort_no_write", 64'(wr_cnt[0] - w0), 64'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    fill(0, 16'h1111, 16'h1111);
    run(0, 1'b0, 0, cyc);
    check_all(0, 16'h0008, "restart");

    // ready held high after completion, then an identical second run.
    fill(0, 16'h1111, 16'h1111);
    run(0, 1'b0, 6, cyc);
    check_all(0, 16'h0008, "held_run");
    mem[0][int'(out_base[0][10:1])]     = 16'hDEAD;
    mem[0][int'(out_base[0][10:1]) + 1] = 16'hDEAD;
    run(0, 1'b0, 0, cyc);
    check_all(0, 16'h0008, "second_run");
    check_value("second_run_len", 64'(cyc), 64'd25);

    // Randomized layers against the reference model.
    for (int it = 0; it < 12; it++) begin
      int g;
      logic mode;
      g = it % 3;
      mode = 1'($urandom_range(0, 1));
      in_base[g]  = 32'h100 + 32'(2 * $urandom_range(0, 31));
      w_base[g]   = 32'h200 + 32'(2 * $urandom_range(0, 63));
      out_base[g] = 32'h600 + 32'(2 * $urandom_range(0, 63));
      stall_cfg[g] = int'($urandom_range(0, 2));
      lat_cfg[g]   = int'($urandom_range(1, 3));
      junk_en[g]   = 1'($urandom_range(0, 1));
      load_random(g);
      w0 = wr_cnt[g];
      run(g, mode, 0, cyc);
      for (int j = 0; j < nout(g); j++)
        check_value($sformatf("rand%0d_d%0d_n%0d", it, g, j),
                    {48'd0, mem[g][int'(out_base[g][10:1]) + j]}, {48'd0, model_node(g, j, mode)});
      check_value($sformatf("rand%0d_writes", it), 64'(wr_cnt[g] - w0), 64'(nout(g)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
